// File: rtl/trig_link_pkg.sv
// trig_link_pkg: shared framing constants, receiver state encoding and helpers for the trigger-phase link
package trig_link_pkg;
    localparam logic [31:0] IDLE_WORD = 32'h33333335;
    localparam logic [7:0]  IDLE_B0   = IDLE_WORD[7:0];
    localparam logic [7:0]  IDLE_BN   = IDLE_WORD[15:8];
    localparam logic [7:0]  TRIG_PAD  = 8'h00;
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} rx_state_t;
    function automatic logic [7:0] bitrev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction
endpackage

// File: rtl/trig_phase_rx.sv
// trig_phase_rx: aligns the byte-serial trigger-phase link, classifies frames and reports triggers
module trig_phase_rx
    import trig_link_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 3
) (
    input  logic        clk160,
    input  logic        resetn,
    input  logic [7:0]  rx_word,
    input  logic        clear_counters,
    output logic        locked,
    output logic        frame_strobe,
    output logic        trig_valid,
    output logic [7:0]  trig_phase,
    output logic [31:0] trig_count,
    output logic [15:0] err_count
);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    rx_state_t     r_state, w_state_nx;
    logic [1:0]    r_slot;
    logic [2:0]    r_idle_f, r_trig_f;
    logic          r_prev_b0;
    logic [LW-1:0] r_idle_run;
    logic [EW-1:0] r_bad_run;
    logic          w_last, w_idle, w_trig, w_err, w_align, w_acc, w_bad;
    assign w_last  = r_state != HUNT && r_slot == 2'd3;
    assign w_idle  = w_last && &r_idle_f && rx_word == IDLE_BN;
    assign w_trig  = w_last && &r_trig_f;
    assign w_err   = w_last && !w_idle && !w_trig;
    assign w_align = r_state == HUNT && r_prev_b0 && rx_word == IDLE_BN;
    assign w_acc   = r_state == LOCKED && w_trig;
    assign w_bad   = r_state == LOCKED && w_err;
    assign locked  = r_state == LOCKED;
    always_comb begin
        w_state_nx = r_state;
        if (w_align)
            w_state_nx = VERIFY;
        else if (r_state == VERIFY && w_last)
            w_state_nx = !w_idle ? HUNT : r_idle_run == LW'(LOCK_COUNT - 1) ? LOCKED : VERIFY;
        else if (w_bad && r_bad_run == EW'(ERR_LIMIT - 1))
            w_state_nx = HUNT;
    end
    always_ff @(posedge clk160) begin
        if (!resetn) begin
            r_state      <= HUNT;
            r_slot       <= '0;
            r_idle_f     <= '0;
            r_trig_f     <= '0;
            r_prev_b0    <= 1'b0;
            r_idle_run   <= '0;
            r_bad_run    <= '0;
            frame_strobe <= 1'b0;
            trig_valid   <= 1'b0;
            trig_phase   <= '0;
            trig_count   <= '0;
            err_count    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_prev_b0 <= rx_word == IDLE_B0;
            r_slot    <= w_align ? 2'd2 : r_slot + 2'd1;
            // the aligning pair already supplied slots 0 and 1 of the first frame
            if (w_align) begin
                r_idle_f <= 3'b011;
                r_trig_f <= 3'b000;
            end else if (r_slot != 2'd3) begin
                r_idle_f[r_slot] <= rx_word == (r_slot == 2'd0 ? IDLE_B0 : IDLE_BN);
                r_trig_f[r_slot] <= rx_word == TRIG_PAD;
            end
            r_idle_run   <= w_state_nx != VERIFY ? '0 : w_idle ? r_idle_run + 1'b1 : r_idle_run;
            r_bad_run    <= w_state_nx != LOCKED ? '0 : w_err ? r_bad_run + 1'b1 : w_last ? '0 : r_bad_run;
            frame_strobe <= w_last;
            trig_valid   <= w_acc;
            trig_phase   <= w_acc ? bitrev8(rx_word) : trig_phase;
            trig_count   <= clear_counters ? '0 : w_acc ? trig_count + 32'd1 : trig_count;
            err_count    <= clear_counters ? '0 : (w_bad && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
        end
    end
endmodule

// File: tb/tb_trig_phase_rx.sv
// tb_trig_phase_rx: directed self-checking bench for the trigger-phase link receiver
module tb_trig_phase_rx;
    logic        clk160 = 1'b0;
    logic        resetn = 1'b0;
    logic        clear_counters = 1'b0;
    logic [7:0]  rx_word = 8'h00;
    logic        locked, frame_strobe, trig_valid;
    logic [7:0]  trig_phase;
    logic [31:0] trig_count;
    logic [15:0] err_count;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          n_strobe = 0;
    int          tv_q[$];
    localparam logic [31:0] IDLE = 32'h33333335;
    localparam logic [31:0] BAD  = 32'hDEADBEEF;

    trig_phase_rx dut (
        .clk160(clk160), .resetn(resetn), .rx_word(rx_word), .clear_counters(clear_counters),
        .locked(locked), .frame_strobe(frame_strobe), .trig_valid(trig_valid),
        .trig_phase(trig_phase), .trig_count(trig_count), .err_count(err_count)
    );

    always #5 clk160 = ~clk160;

    task automatic cyc(input logic [7:0] b);
        rx_word = b;
        @(negedge clk160);
        cyc_n++;
        if (frame_strobe) n_strobe++;
        if (trig_valid) tv_q.push_back(cyc_n);
    endtask

    task automatic frame(input logic [31:0] w);
        for (int i = 0; i < 4; i++) cyc(w[8*i +: 8]);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        n_strobe = 0;
        frame(IDLE);
        frame(IDLE);
        n_checks++;
        if ({locked, frame_strobe, trig_valid, trig_phase, trig_count, err_count} !== 59'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got l=%0b fs=%0b tv=%0b ph=%h tc=%0d ec=%0d want all 0",
                     locked, frame_strobe, trig_valid, trig_phase, trig_count, err_count);
        end
        n_checks++;
        if (n_strobe !== 0) begin
            n_fail++;
            $display("FAIL reset_no_strobe: got %0d strobes want 0", n_strobe);
        end
    endtask

    task automatic test_idle_lock;
        resetn = 1'b1;
        n_strobe = 0;
        cyc(8'h33);
        cyc(8'h33);
        for (int f = 1; f <= 4; f++) begin
            cyc(8'h35); cyc(8'h33); cyc(8'h33);
            n_checks++;
            if (locked !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_early f%0d: got locked=%0b want 0", f, locked);
            end
            cyc(8'h33);
            n_checks++;
            if (locked !== (f == 4) || frame_strobe !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_frame f%0d: got locked=%0b fs=%0b want locked=%0b fs=1",
                         f, locked, frame_strobe, f == 4);
            end
        end
        n_checks++;
        if (n_strobe !== 4 || trig_count !== 32'd0 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL lock_counts: got strobes=%0d tc=%0d ec=%0d want 4 0 0", n_strobe, trig_count, err_count);
        end
    endtask

    task automatic test_trigger;
        tv_q.delete();
        cyc(8'h00); cyc(8'h00); cyc(8'h00);
        n_checks++;
        if (trig_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trig_early: got tv=%0b want 0", trig_valid);
        end
        cyc(8'hC0);
        n_checks++;
        if (trig_valid !== 1'b1 || trig_phase !== 8'h03 || trig_count !== 32'd1) begin
            n_fail++;
            $display("FAIL trig_first: got tv=%0b ph=%h tc=%0d want 1 03 1", trig_valid, trig_phase, trig_count);
        end
        cyc(8'h00);
        n_checks++;
        if (trig_valid !== 1'b0 || trig_phase !== 8'h03) begin
            n_fail++;
            $display("FAIL trig_pulse_width: got tv=%0b ph=%h want 0 03", trig_valid, trig_phase);
        end
        cyc(8'h00); cyc(8'h00); cyc(8'h01);
        frame(32'h80000000);
        frame(32'h1E000000);
        n_checks++;
        if (trig_count !== 32'd4 || trig_phase !== 8'h78 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL trig_b2b: got tc=%0d ph=%h l=%0b want 4 78 1", trig_count, trig_phase, locked);
        end
        n_checks++;
        if (tv_q.size() !== 4) begin
            n_fail++;
            $display("FAIL trig_pulses: got %0d pulses want 4", tv_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (tv_q[k+1] - tv_q[k] !== 4) begin
                    n_fail++;
                    $display("FAIL trig_spacing %0d: got %0d cycles want 4", k, tv_q[k+1] - tv_q[k]);
                end
            end
        end
    endtask

    task automatic test_errors;
        frame(32'h12345678);
        frame(32'hFFFFFFFF);
        frame(IDLE);
        n_checks++;
        if (err_count !== 16'd2 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL err_two: got ec=%0d l=%0b want 2 1", err_count, locked);
        end
        frame(BAD);
        frame(32'h00000001);
        n_checks++;
        if (err_count !== 16'd4 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL err_run2: got ec=%0d l=%0b want 4 1", err_count, locked);
        end
        frame(32'h33333333);
        n_checks++;
        if (err_count !== 16'd5 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL err_unlock: got ec=%0d l=%0b want 5 0", err_count, locked);
        end
        n_strobe = 0;
        frame(32'h00000000);
        n_checks++;
        if (n_strobe !== 0 || err_count !== 16'd5 || trig_count !== 32'd4) begin
            n_fail++;
            $display("FAIL err_hunt: got strobes=%0d ec=%0d tc=%0d want 0 5 4", n_strobe, err_count, trig_count);
        end
    endtask

    task automatic test_slip;
        for (int f = 1; f <= 4; f++) frame(IDLE);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL slip_relock0: got l=%0b want 1", locked);
        end
        cyc(8'h33);
        frame(IDLE);
        frame(IDLE);
        n_checks++;
        if (err_count !== 16'd7 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL slip_err2: got ec=%0d l=%0b want 7 1", err_count, locked);
        end
        frame(IDLE);
        n_checks++;
        if (err_count !== 16'd8 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL slip_unlock: got ec=%0d l=%0b want 8 0", err_count, locked);
        end
        for (int f = 1; f <= 3; f++) frame(IDLE);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL slip_verify: got l=%0b want 0", locked);
        end
        frame(IDLE);
        n_checks++;
        if (locked !== 1'b1 || err_count !== 16'd8) begin
            n_fail++;
            $display("FAIL slip_relock: got l=%0b ec=%0d want 1 8", locked, err_count);
        end
    endtask

    task automatic test_saturate_clear;
        force dut.err_count = 16'hFFFD;
        #1;
        release dut.err_count;
        frame(BAD);
        n_checks++;
        if (err_count !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_step: got ec=%h want fffe", err_count);
        end
        frame(BAD);
        frame(IDLE);
        frame(BAD);
        n_checks++;
        if (err_count !== 16'hFFFF || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold: got ec=%h l=%0b want ffff 1", err_count, locked);
        end
        frame(IDLE);
        cyc(8'h00); cyc(8'h00); cyc(8'h00);
        clear_counters = 1'b1;
        cyc(8'h80);
        clear_counters = 1'b0;
        n_checks++;
        if (trig_valid !== 1'b1 || trig_phase !== 8'h01 || trig_count !== 32'd0 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_vs_trig: got tv=%0b ph=%h tc=%0d ec=%0d want 1 01 0 0",
                     trig_valid, trig_phase, trig_count, err_count);
        end
        frame(32'h02000000);
        frame(BAD);
        n_checks++;
        if (trig_count !== 32'd1 || trig_phase !== 8'h40 || err_count !== 16'd1) begin
            n_fail++;
            $display("FAIL post_clear: got tc=%0d ph=%h ec=%0d want 1 40 1", trig_count, trig_phase, err_count);
        end
    endtask

    task automatic test_reset_mid;
        frame(IDLE);
        cyc(8'h35);
        cyc(8'h33);
        resetn = 1'b0;
        cyc(8'h33);
        n_checks++;
        if ({locked, frame_strobe, trig_valid, trig_phase, trig_count, err_count} !== 59'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got l=%0b fs=%0b tv=%0b ph=%h tc=%0d ec=%0d want all 0",
                     locked, frame_strobe, trig_valid, trig_phase, trig_count, err_count);
        end
        resetn = 1'b1;
        cyc(8'h33);
        for (int f = 1; f <= 3; f++) frame(IDLE);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_verify: got l=%0b want 0", locked);
        end
        frame(IDLE);
        n_checks++;
        if (locked !== 1'b1 || trig_count !== 32'd0 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_relock: got l=%0b tc=%0d ec=%0d want 1 0 0", locked, trig_count, err_count);
        end
    endtask

    initial begin
        @(negedge clk160);
        test_reset;
        test_idle_lock;
        test_trigger;
        test_errors;
        test_slip;
        test_saturate_clear;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trig_phase_rx.md
# trig_phase_rx

Receiver for the clk160 byte-serial trigger-phase link driven by the external-trigger logic. It recovers 32-bit frame alignment from the idle pattern, classifies each frame as idle, trigger or error, and reports each trigger as a one-cycle pulse with its bit-reversed phase byte restored. Counters and lock status feed the downstream IPIF register block.

## Interface
- `LOCK_COUNT`, default 4: consecutive idle frames required in VERIFY before asserting lock.
- `ERR_LIMIT`, default 3: consecutive error frames in LOCKED that force a return to HUNT.
- `clk160` input 1: link byte clock. The block uses only this clock.
- `resetn` input 1: reset, synchronous and active-low.
- `rx_word` input 8: link byte, sampled on every rising edge.
- `clear_counters` input 1: synchronous clear of `trig_count` and `err_count`.
- `locked` output 1: high while in LOCKED.
- `frame_strobe` output 1: one-cycle pulse per completed frame, while in VERIFY or LOCKED.
- `trig_valid` output 1: one-cycle pulse per accepted trigger frame.
- `trig_phase` output 8: recovered phase, valid with `trig_valid` and held until the next trigger.
- `trig_count` output 32: accepted triggers; wraps modulo 2^32.
- `err_count` output 16: error frames seen in LOCKED; saturates at 0xFFFF.

## Operation
- Frame format: 4 bytes, slot 0 first.
  - Idle frame: slots 0..3 = 0x35, 0x33, 0x33, 0x33 (the 32-bit idle word 0x33333335, sent LSB byte first).
  - Trigger frame: slots 0..2 = 0x00, slot 3 = P.
  - `trig_phase` = bit-reverse(P), so `trig_phase[0]` = P[7].
- Any other frame is an error frame.
- State machine HUNT / VERIFY / LOCKED, with a 2-bit slot counter.
- HUNT:
  - Trigger: `rx_word` == 0x35 in cycle T and 0x33 in cycle T+1.
  - Action: treat cycle T as slot 0, the cycle T+1 byte as slot 1, and enter VERIFY; frame check covers the whole aligned frame.
  - No frame classification in HUNT; `frame_strobe` stays low.
- VERIFY:
  - Each idle frame increments the idle run; reaching `LOCK_COUNT` enters LOCKED. The aligning frame counts as the first.
  - Any non-idle frame: return to HUNT, clear the idle run. Triggers are not reported.
- LOCKED:
  - Idle frame: clear the bad run.
  - Trigger frame: pulse `trig_valid`, load `trig_phase`, increment `trig_count`, clear the bad run. Back-to-back trigger frames are each reported.
  - Error frame: increment `err_count` (saturating) and the bad run. When the bad run reaches `ERR_LIMIT`, enter HUNT with `locked` low.
- Slot counter wraps 3→0 freely; there is no realignment while LOCKED.
- `clear_counters` coinciding with an increment: the clear wins, and the counter reads 0 next cycle.

## Timing
- Reset state: all outputs 0, state HUNT, slot, idle run and bad run all 0. Reset takes priority over all other inputs, including mid-frame.
- Classification happens on the edge that samples the slot-3 byte (cycle T). `frame_strobe`, `trig_valid`, `trig_phase` and the counters update so they are visible in cycle T+1: latency 1 cycle from the slot-3 byte.
- `locked` rises in the cycle after the `LOCK_COUNT`-th idle frame's slot-3 byte. It falls in the cycle after the `ERR_LIMIT`-th error frame's slot-3 byte.
- Minimum spacing between `trig_valid` pulses is 4 cycles.
- Fast path: the slot-0..2 comparisons are registered per slot as three flag bits. Only the slot-3 compare is combinational from `rx_word`.

## Structure
- Package `trig_link_pkg`:
  - `IDLE_WORD` = 32'h33333335, plus `IDLE_B0` = 8'h35 and `IDLE_BN` = 8'h33.
  - `TRIG_PAD` = 8'h00.
  - Enum `rx_state_t` {HUNT, VERIFY, LOCKED}.
  - Function `bitrev8`.
  - The transmitter side imports the same package.
- Single module. Counters live inline; no sub-module is required.

## Test plan
- Continuous idle stream starting at an arbitrary slot: `locked` rises exactly 4 frames after the first 0x35,0x33 pair; `frame_strobe` every 4 cycles; counters remain 0.
- Locked, inject frame 00,00,00,0xC0: one `trig_valid` pulse 1 cycle after the 0xC0 byte, `trig_phase` = 0x03, `trig_count` = 1. Then three back-to-back trigger frames: `trig_count` = 4, pulses spaced 4 cycles apart.
- Locked, inject 2 error frames then idle: `err_count` = 2, `locked` stays high. Then 3 consecutive error frames: `locked` falls after the third, state HUNT, `err_count` = 5.
- Slip the stream by one byte while locked: `err_count` grows by 3, unlock, relock after 4 idle frames at the new alignment.
- `err_count` preset near 0xFFFF via a long error stream: saturates at 0xFFFF. `clear_counters` on the same cycle as a trigger: `trig_count` = 0.
- Deassert `resetn` mid-frame while locked with counters nonzero: next cycle all outputs 0 and state HUNT. Relock proceeds normally after release.
